// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULTU/DIVU sequencer: ALU control codes,
// operation codes, FSM state encoding and the last iteration index.
package muldiv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [4:0] ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the MULTU/DIVU sequence. Chooses the ALU operation and
// operands for the current {hi,lo} state and folds the ALU result back
// into the next {hi,lo}. The ALU is external and is not visible here
// beyond its 32-bit result, so the carry and borrow out are rebuilt from
// the operand and result MSBs.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] opnd,
  input  logic [31:0] alu_result,
  output logic [2:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  // Carry out of a 32-bit add, from the operand and sum MSBs.
  function automatic logic add_carry(input logic a, input logic b, input logic r);
    return (a & b) | ((a | b) & ~r);
  endfunction

  // Borrow out of a 32-bit subtract, from the operand and difference MSBs.
  function automatic logic sub_borrow(input logic a, input logic b, input logic r);
    return (~a & b) | ((~a | b) & r);
  endfunction

  logic [31:0] t;
  logic        m;
  logic        c;
  logic        w;

  // Shift-add for multiply, restoring subtraction for divide.
  always_comb begin
    t       = {hi[30:0], lo[31]};
    m       = hi[31];
    c       = 1'b0;
    w       = 1'b0;
    alu_ctl = ALU_ADD;
    alu_a   = hi;
    alu_b   = opnd;
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (op == OP_DIVU) begin
      alu_ctl = ALU_SUB;
      alu_a   = t;
      w       = sub_borrow(t[31], opnd[31], alu_result[31]);
      // The bit shifted out of hi (m) makes the partial remainder 33 bits,
      // so it always covers the divisor even when the 32-bit subtract borrows.
      if (m | ~w) begin
        hi_nxt = alu_result;
        lo_nxt = {lo[30:0], 1'b1};
      end else begin
        hi_nxt = t;
        lo_nxt = {lo[30:0], 1'b0};
      end
    end else begin
      c = add_carry(hi[31], opnd[31], alu_result[31]);
      if (lo[0]) begin
        {hi_nxt, lo_nxt} = {c, alu_result, lo[31:1]};
      end else begin
        {hi_nxt, lo_nxt} = {1'b0, hi, lo[31:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULTU/DIVU sequencer owning HI/LO. Drives the shared ALU once
// per cycle for 32 cycles, raising busy so dependent MFHI/MFLO stall.
// Build option MULDIV_EARLY_OUT_EN: trivial operands (multiply by zero,
// divide by zero) load the final result on the start edge and skip RUN.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [2:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result
);

  localparam int CNT_W = $clog2(ITER);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             op_q;
  logic [31:0]      opnd;

  logic [2:0]  step_ctl;
  logic [31:0] step_a;
  logic [31:0] step_b;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;

  logic        trivial;
  logic [31:0] triv_hi;
  logic [31:0] triv_lo;

  muldiv_step u_step (
    .op         (op_q),
    .hi         (hi),
    .lo         (lo),
    .opnd       (opnd),
    .alu_result (alu_result),
    .alu_ctl    (step_ctl),
    .alu_a      (step_a),
    .alu_b      (step_b),
    .hi_nxt     (hi_nxt),
    .lo_nxt     (lo_nxt)
  );

  // ALU is only claimed in RUN; otherwise present a harmless ADD of hi/opnd.
  always_comb begin
    alu_ctl = ALU_ADD;
    alu_a   = hi;
    alu_b   = opnd;
    if (state == RUN) begin
      alu_ctl = step_ctl;
      alu_a   = step_a;
      alu_b   = step_b;
    end
  end

  // Detect operands whose result is known without iterating.
  always_comb begin
    trivial = 1'b0;
    triv_hi = '0;
    triv_lo = '0;
`ifdef MULDIV_EARLY_OUT_EN
    if (op == OP_DIVU) begin
      trivial = (src_b == '0);
      triv_hi = src_a;
      triv_lo = '1;
    end else begin
      trivial = (src_a == '0) || (src_b == '0);
    end
`endif
  end

  // Sequencer FSM, iteration counter and HI/LO/operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
      opnd  <= '0;
      op_q  <= OP_MULTU;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op_q  <= op;
            opnd  <= op ? src_b : src_a;
            count <= '0;
            if (trivial) begin
              hi    <= triv_hi;
              lo    <= triv_lo;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              hi    <= '0;
              lo    <= op ? src_a : src_b;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            count <= count + 1'b1;
            if (count == CNT_W'(ITER_LAST)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural ALU alongside it.
// Honours MULDIV_EARLY_OUT_EN for the expected latency of trivial operands.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // External ALU model.
  always_comb begin
    case (alu_ctl)
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  muldiv_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit is_trivial(input logic o, input logic [31:0] a, input logic [31:0] b);
    bit t;
    t = o ? (b == 0) : ((a == 0) || (b == 0));
`ifdef MULDIV_EARLY_OUT_EN
    return t;
`else
    return t & 1'b0;
`endif
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(input string name, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int busy_cycles;
    int done_cyc;
    int exp_lat;
    int exp_busy;
    busy_cycles = 0;
    done_cyc    = 0;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) done_cyc = cyc;
    end
    exp_lat  = is_trivial(o, a, b) ? 1 : 33;
    exp_busy = is_trivial(o, a, b) ? 0 : 32;
    check({name, " done cycle"}, 32'(done_cyc), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(busy_cycles), 32'(exp_busy));
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
  endtask

  initial begin
    int ndone;

    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[2]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[3]  = '{1'b1, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF};
    vecs[4]  = '{1'b0, 32'd6,        32'd7,        32'd0,        32'd42};
    vecs[5]  = '{1'b1, 32'd9,        32'd3,        32'd0,        32'd3};
    vecs[6]  = '{1'b0, 32'd0,        32'd5,        32'd0,        32'd0};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[8]  = '{1'b0, 32'h80000000, 32'd2,        32'd1,        32'd0};
    vecs[9]  = '{1'b1, 32'd5,        32'd10,       32'd5,        32'd0};
    vecs[10] = '{1'b0, 32'h12345678, 32'h10,       32'd1,        32'h23456780};
    vecs[11] = '{1'b1, 32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    src_a = '0;
    src_b = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset alu_ctl", 32'(alu_ctl), 32'd2);
    check("reset alu_a", alu_a, 32'd0);
    check("reset alu_b", alu_b, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo);
      @(negedge clk);
    end

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold hi", hi, 32'd2);
    check("hold lo", lo, 32'h2AAAAAAA);

    // start and flush together in IDLE: nothing launches.
    start = 1'b1;
    flush = 1'b1;
    op    = 1'b0;
    src_a = 32'd3;
    src_b = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("start+flush busy", 32'(busy), 32'd0);
    check("start+flush done", 32'(done), 32'd0);
    @(negedge clk);
    check("start+flush busy later", 32'(busy), 32'd0);
    check("start+flush hi kept", hi, 32'd2);

    // start held high through RUN and DONE: only the first op executes.
    ndone = 0;
    start = 1'b1;
    op    = 1'b0;
    src_a = 32'd6;
    src_b = 32'd7;
    @(posedge clk);
    #1 op = 1'b1;
    src_a = 32'd9;
    src_b = 32'd3;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    @(negedge clk);
    check("repeat-start busy after done", 32'(busy), 32'd0);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("repeat-start done pulses", 32'(ndone), 32'd1);
    check("repeat-start hi", hi, 32'd0);
    check("repeat-start lo", lo, 32'd42);

    // flush at RUN cycle 10, then DIVU 9 / 3 on the next cycle.
    ndone = 0;
    start = 1'b1;
    op    = 1'b0;
    src_a = 32'hFFFFFFFF;
    src_b = 32'hFFFFFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (done) ndone++;
    check("flush busy", 32'(busy), 32'd0);
    check("flush no done", 32'(ndone), 32'd0);
    run_op("after flush", 1'b1, 32'd9, 32'd3, 32'd0, 32'd3);
    @(negedge clk);

    // Asynchronous reset during RUN cycle 5.
    start = 1'b1;
    op    = 1'b0;
    src_a = 32'hFFFFFFFF;
    src_b = 32'hFFFFFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset done", 32'(done), 32'd0);
    check("mid reset hi", hi, 32'd0);
    check("mid reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after reset", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative sequencer that executes MIPS MULTU/DIVU by driving the shared 32-bit ALU once per cycle: shift-add for multiply, restoring subtraction for divide. It owns the HI/LO registers and sits beside the EX stage. While an operation runs it raises busy so the hazard unit stalls dependent MFHI/MFLO.

Parameters:
- ITER, 32, iteration count; equals the data width and is fixed.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch request from EX; sampled only in IDLE.
- op  in  1  0 = MULTU, 1 = DIVU.
- src_a  in  32  multiplicand / dividend.
- src_b  in  32  multiplier / divisor.
- flush  in  1  pipeline flush; aborts an operation in progress.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- hi  out  32  HI register.
- lo  out  32  LO register.
- alu_ctl  out  3  ALU control code; ADD = 3'b010, SUB = 3'b110.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_result  in  32  combinational ALU result, used in the same cycle.

Behaviour:
- Reset: async to IDLE; hi, lo, busy, done, count, divisor/multiplicand register all 0; alu_ctl = ADD; alu_a = alu_b = 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start & ~flush. The start edge loads:
  - hi = 0; lo = op ? src_a : src_b.
  - opnd = op ? src_b : src_a.
  - count = 0; op is latched.
- RUN: one iteration per cycle. After iteration count = 31, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge T; busy is high T+1..T+32; done is high T+33; hi/lo are final from T+33.
- hi/lo hold their value until the next accepted start.
- Carry and borrow are derived from the MSBs (r = alu_result):
  - add carry c = (a31&b31) | ((a31|b31)&~r31).
  - sub borrow w = (~a31&b31) | ((~a31|b31)&r31).
- MULTU iteration: alu_ctl = ADD, alu_a = hi, alu_b = opnd.
  - If lo[0]: {hi,lo} <= {c, r, lo[31:1]} (33 MSBs + 31 bits).
  - Else: {hi,lo} <= {1'b0, hi, lo[31:1]}.
- DIVU iteration: t = {hi[30:0], lo[31]}, m = hi[31]; alu_ctl = SUB, alu_a = t, alu_b = opnd.
  - If m | ~w: hi <= r, lo <= {lo[30:0], 1}.
  - Else: hi <= t, lo <= {lo[30:0], 0}.
- Divide by zero runs the full sequence and yields lo = 32'hFFFFFFFF, hi = dividend. No exception is raised.
- start while busy or in DONE: ignored; no queuing.
- flush in RUN: next edge goes to IDLE; no done; hi/lo keep partial values.
- flush in DONE: done is still pulsed; results are kept.
- start & flush together in IDLE: flush wins; nothing is launched.
- In IDLE/DONE, ALU outputs are driven as ADD with alu_a = hi, alu_b = opnd. No glitch requirement.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: on the start edge, if the trivial-operand condition below holds, load the final hi/lo directly and go straight to DONE. done is then high at T+1 and busy never rises.
  - MULTU with src_a == 0 or src_b == 0: hi = lo = 0.
  - DIVU with src_b == 0: lo = 32'hFFFFFFFF, hi = src_a.
- Undefined: all operations take the full 33-cycle latency.
- Results are identical in both builds.

Decomposition:
- muldiv_pkg holds:
  - ALU_ADD / ALU_SUB codes.
  - OP_MULTU / OP_DIVU.
  - State encoding IDLE/RUN/DONE.
  - ITER_LAST = 31.
- One sub-module, muldiv_step: combinational next-{hi,lo} from op, hi, lo, opnd and alu_result, including carry/borrow derivation. The top keeps the FSM, counter and registers.
- The ALU itself stays external and is shared with EX through the operand mux owned by the datapath.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at T+33 done = 1, hi = 0xFFFFFFFE, lo = 0x00000001; busy high exactly 32 cycles.
- DIVU 100 / 7 -> lo = 14, hi = 2; MULTU 0x00010000 x 0x00010000 -> hi = 1, lo = 0.
- DIVU 0x12345678 / 0 -> lo = 0xFFFFFFFF, hi = 0x12345678. Without MULDIV_EARLY_OUT_EN done at T+33; with it, done at T+1.
- start pulsed every cycle during RUN -> only the first operation runs; exactly one done pulse; result matches the first operands.
- flush at RUN cycle 10, then new DIVU 9 / 3 next cycle -> no done for the aborted op; second op gives lo = 3, hi = 0.
- rst_n low at RUN cycle 5 -> immediately busy = 0, hi = lo = 0, state IDLE; after release a new MULTU 6 x 7 gives lo = 42, hi = 0.
